// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-CPU sequencer: control word layout,
// ALU codes, T-state numbering and the 16-instruction opcode map.
package ctrl_pkg;

  localparam int unsigned CTRL_NUM = 20;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned NUM_OPS  = 17;

  // Control word, MSB first, in datapath strobe order
  typedef struct packed {
    logic ar_load;
    logic ar_inc;
    logic pc_load;
    logic pc_inc;
    logic dr_load;
    logic ir_load;
    logic tr_load;
    logic r_load;
    logic ac_load;
    logic z_load;
    logic pc_bus;
    logic drl_bus;
    logic drh_bus;
    logic tr_bus;
    logic r_bus;
    logic ac_bus;
    logic mem_read;
    logic mem_write;
    logic mem2bus;
    logic bus2mem;
  } ctrl_t;

  // Register load/increment strobes; these are held off during memory wait states
  localparam logic [CTRL_NUM-1:0] STROBE_MASK = 20'hFFC00;

  localparam logic [3:0] ALUS_CLAC = 4'h0;
  localparam logic [3:0] ALUS_ADD  = 4'h1;
  localparam logic [3:0] ALUS_SUB  = 4'h2;
  localparam logic [3:0] ALUS_INAC = 4'h3;
  localparam logic [3:0] ALUS_AND  = 4'h4;
  localparam logic [3:0] ALUS_OR   = 4'h5;
  localparam logic [3:0] ALUS_NOT  = 4'h6;
  localparam logic [3:0] ALUS_XOR  = 4'h7;
  localparam logic [3:0] ALUS_PASS = 4'h8;
  localparam logic [3:0] ALUS_IDLE = 4'hF;

  localparam int unsigned T_FETCH1 = 0;
  localparam int unsigned T_FETCH2 = 1;
  localparam int unsigned T_FETCH3 = 2;
  localparam int unsigned T_EXEC1  = 3;
  localparam int unsigned T_EXEC5  = 7;

  // One-hot positions; the low 16 equal the opcode value
  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_LDAC = 1;
  localparam int unsigned OP_STAC = 2;
  localparam int unsigned OP_MVAC = 3;
  localparam int unsigned OP_MOVR = 4;
  localparam int unsigned OP_JUMP = 5;
  localparam int unsigned OP_JMPZ = 6;
  localparam int unsigned OP_JPNZ = 7;
  localparam int unsigned OP_ADD  = 8;
  localparam int unsigned OP_SUB  = 9;
  localparam int unsigned OP_INAC = 10;
  localparam int unsigned OP_CLAC = 11;
  localparam int unsigned OP_AND  = 12;
  localparam int unsigned OP_OR   = 13;
  localparam int unsigned OP_XOR  = 14;
  localparam int unsigned OP_NOT  = 15;
  localparam int unsigned OP_HALT = 16;

endpackage

// File: rtl/seq_decode.sv
// Opcode decoder: one-hot instruction class, execute length and illegal flag.
module seq_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned    OPW     = 8,
  parameter logic [OPW-1:0] HALT_OP = OPW'(8'h10)
) (
  input  logic [OPW-1:0]     instr,
  input  logic               z_sel,
  output logic [NUM_OPS-1:0] op,
  output logic [LEN_W-1:0]   exec_len,
  output logic               illegal
);

  always_comb begin
    op       = '0;
    exec_len = LEN_W'(1);
    illegal  = 1'b0;

    if (instr == HALT_OP) begin
      op = NUM_OPS'(1) << OP_HALT;
    end else if (instr < OPW'(16)) begin
      op = NUM_OPS'(1) << instr[3:0];
    end else begin
      op      = NUM_OPS'(1) << OP_NOP;
      illegal = 1'b1;
    end

    // Branches run the full JUMP sequence only when taken
    if (op[OP_LDAC] || op[OP_STAC]) begin
      exec_len = LEN_W'(5);
    end else if (op[OP_JUMP]) begin
      exec_len = LEN_W'(3);
    end else if (op[OP_JMPZ]) begin
      exec_len = z_sel ? LEN_W'(3) : LEN_W'(2);
    end else if (op[OP_JPNZ]) begin
      exec_len = z_sel ? LEN_W'(2) : LEN_W'(3);
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Hardwired sequencer: binary T-state counter, wait-state stall, halt and
// illegal tracking, and the packed control word for datapath and memory.
module seq_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned    OPW     = 8,
  parameter int unsigned    TW      = 3,
  parameter int unsigned    CTRL_W  = 20,
  parameter logic [OPW-1:0] HALT_OP = OPW'(8'h10)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [OPW-1:0]    instr,
  input  logic              z,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        alus,
  output logic [TW-1:0]     tstate,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal
);

  logic [TW-1:0]       tstate_d;
  logic                z_q, z_q_d, halted_d, illegal_d;
  logic                active, in_exec, at_exec1, z_sel;
  logic [NUM_OPS-1:0]  op;
  logic [LEN_W-1:0]    exec_len;
  logic                dec_illegal;
  logic [TW-1:0]       step;
  logic                branch_op, taken, jump_path, last, stall;
  ctrl_t               word;
  logic [CTRL_NUM-1:0] word_bits;
  logic [3:0]          alus_raw;

  // Reset low also gates the strobes so memory writes drop without a clock edge
  assign active    = reset & run & ~halted;
  assign in_exec   = tstate >= TW'(T_EXEC1);
  assign at_exec1  = tstate == TW'(T_EXEC1);
  assign z_sel     = at_exec1 ? z : z_q;
  assign step      = tstate - TW'(T_EXEC1);

  seq_decode #(
    .OPW     (OPW),
    .HALT_OP (HALT_OP)
  ) u_decode (
    .instr    (instr),
    .z_sel    (z_sel),
    .op       (op),
    .exec_len (exec_len),
    .illegal  (dec_illegal)
  );

  assign branch_op = op[OP_JMPZ] | op[OP_JPNZ];
  assign taken     = branch_op & (exec_len == LEN_W'(3));
  assign jump_path = op[OP_JUMP] | taken;

  // Raw control word and ALU select for the current T-state
  always_comb begin
    word     = '0;
    alus_raw = ALUS_IDLE;
    if (tstate == TW'(T_FETCH1)) begin
      word.ar_load = 1'b1;
      word.pc_bus  = 1'b1;
    end else if (tstate == TW'(T_FETCH2)) begin
      word.mem_read = 1'b1;
      word.mem2bus  = 1'b1;
      word.dr_load  = 1'b1;
      word.pc_inc   = 1'b1;
    end else if (tstate == TW'(T_FETCH3)) begin
      word.ir_load = 1'b1;
      word.ar_load = 1'b1;
      word.pc_bus  = 1'b1;
    end else if (op[OP_LDAC] || op[OP_STAC]) begin
      case (step)
        TW'(0): begin
          word.mem_read = 1'b1;
          word.mem2bus  = 1'b1;
          word.dr_load  = 1'b1;
          word.pc_inc   = 1'b1;
          word.ar_inc   = 1'b1;
        end
        TW'(1): begin
          word.tr_load  = 1'b1;
          word.dr_load  = 1'b1;
          word.pc_inc   = 1'b1;
          word.mem_read = 1'b1;
          word.mem2bus  = 1'b1;
        end
        TW'(2): begin
          word.ar_load = 1'b1;
          word.drh_bus = 1'b1;
          word.tr_bus  = 1'b1;
        end
        TW'(3): begin
          word.dr_load  = 1'b1;
          word.mem_read = op[OP_LDAC];
          word.mem2bus  = op[OP_LDAC];
          word.ac_bus   = op[OP_STAC];
        end
        default: begin
          word.drl_bus   = 1'b1;
          word.ac_load   = op[OP_LDAC];
          word.mem_write = op[OP_STAC];
          word.bus2mem   = op[OP_STAC];
          alus_raw       = op[OP_LDAC] ? ALUS_PASS : ALUS_IDLE;
        end
      endcase
    end else if (jump_path) begin
      case (step)
        TW'(0): begin
          word.mem_read = 1'b1;
          word.mem2bus  = 1'b1;
          word.dr_load  = 1'b1;
          word.ar_inc   = 1'b1;
        end
        TW'(1): begin
          word.tr_load  = 1'b1;
          word.dr_load  = 1'b1;
          word.mem_read = 1'b1;
          word.mem2bus  = 1'b1;
        end
        default: begin
          word.pc_load = 1'b1;
          word.drh_bus = 1'b1;
          word.tr_bus  = 1'b1;
        end
      endcase
    end else if (branch_op) begin
      word.pc_inc = 1'b1;
    end else if (op[OP_MVAC]) begin
      word.r_load = 1'b1;
      word.ac_bus = 1'b1;
    end else if (op[OP_MOVR]) begin
      word.ac_load = 1'b1;
      word.r_bus   = 1'b1;
      alus_raw     = ALUS_PASS;
    end else if (op[OP_NOP] || op[OP_HALT]) begin
      word = '0;
    end else begin
      word.ac_load = 1'b1;
      word.z_load  = 1'b1;
      word.r_bus   = op[OP_ADD] | op[OP_SUB] | op[OP_AND] | op[OP_OR] | op[OP_XOR];
      if (op[OP_ADD])       alus_raw = ALUS_ADD;
      else if (op[OP_SUB])  alus_raw = ALUS_SUB;
      else if (op[OP_INAC]) alus_raw = ALUS_INAC;
      else if (op[OP_CLAC]) alus_raw = ALUS_CLAC;
      else if (op[OP_AND])  alus_raw = ALUS_AND;
      else if (op[OP_OR])   alus_raw = ALUS_OR;
      else if (op[OP_XOR])  alus_raw = ALUS_XOR;
      else                  alus_raw = ALUS_NOT;
    end
  end

  assign word_bits  = word;
  assign stall      = (word.mem_read | word.mem_write) & ~mem_ready;
  assign last       = in_exec & (step == TW'(exec_len) - TW'(1));
  assign instr_done = active & last & ~stall;

  // Load/increment strobes fire only on the cycle memory completes
  assign ctrl = active ? CTRL_W'(stall ? (word_bits & ~STROBE_MASK) : word_bits) : '0;
  assign alus = active ? alus_raw : ALUS_IDLE;

  always_comb begin
    tstate_d  = tstate;
    z_q_d     = z_q;
    halted_d  = halted;
    illegal_d = illegal;
    if (active) begin
      if (at_exec1) begin
        z_q_d     = z;
        illegal_d = illegal | dec_illegal;
      end
      if (instr_done) begin
        tstate_d = '0;
        halted_d = halted | op[OP_HALT];
      end else if (!stall) begin
        tstate_d = tstate + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tstate  <= '0;
      z_q     <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      tstate  <= tstate_d;
      z_q     <= z_q_d;
      halted  <= halted_d;
      illegal <= illegal_d;
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: fetch, wait states, branches, halt,
// illegal opcodes, run freeze and asynchronous reset mid-write.
module tb_seq_controller;

  localparam logic [19:0] AR_LOAD = 20'h80000;
  localparam logic [19:0] AR_INC  = 20'h40000;
  localparam logic [19:0] PC_LOAD = 20'h20000;
  localparam logic [19:0] PC_INC  = 20'h10000;
  localparam logic [19:0] DR_LOAD = 20'h08000;
  localparam logic [19:0] IR_LOAD = 20'h04000;
  localparam logic [19:0] TR_LOAD = 20'h02000;
  localparam logic [19:0] AC_LOAD = 20'h00800;
  localparam logic [19:0] Z_LOAD  = 20'h00400;
  localparam logic [19:0] PC_BUS  = 20'h00200;
  localparam logic [19:0] DRL_BUS = 20'h00100;
  localparam logic [19:0] DRH_BUS = 20'h00080;
  localparam logic [19:0] TR_BUS  = 20'h00040;
  localparam logic [19:0] R_BUS   = 20'h00020;
  localparam logic [19:0] AC_BUS  = 20'h00010;
  localparam logic [19:0] MEM_RD  = 20'h00008;
  localparam logic [19:0] MEM_WR  = 20'h00004;
  localparam logic [19:0] MEM2BUS = 20'h00002;
  localparam logic [19:0] BUS2MEM = 20'h00001;

  logic        clk = 1'b0;
  logic        reset, run, z, mem_ready;
  logic [7:0]  instr;
  logic [19:0] ctrl;
  logic [3:0]  alus;
  logic [2:0]  tstate;
  logic        instr_done, halted, illegal;

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] clog [40];
  logic [2:0]  tlog [40];
  logic [3:0]  alog [40];
  int          ncyc;

  always #5 clk = ~clk;

  seq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr      (instr),
    .z          (z),
    .mem_ready  (mem_ready),
    .ctrl       (ctrl),
    .alus       (alus),
    .tstate     (tstate),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH1, logging every cycle until instr_done
  task automatic run_instr(input logic [7:0] opc, input int stall_t, input int stall_n,
                           input logic z_early, input logic z_late);
    int   left = stall_n;
    logic seen = 1'b0;
    instr = opc;
    ncyc  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      z         = (32'(tstate) >= 4) ? z_late : z_early;
      mem_ready = !((32'(tstate) == stall_t) && (left > 0));
      if (!mem_ready) left--;
      #1;
      clog[i] = ctrl;
      tlog[i] = tstate;
      alog[i] = alus;
      ncyc    = i + 1;
      seen    = instr_done;
      tick();
    end
    mem_ready = 1'b1;
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  function automatic int cnt(input logic [19:0] mask, input int t);
    int c = 0;
    for (int i = 0; i < ncyc; i++)
      if (((clog[i] & mask) != 20'h0) && (t < 0 || 32'(tlog[i]) == t)) c++;
    return c;
  endfunction

  initial begin
    reset = 1'b0; run = 1'b1; instr = 8'h00; z = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_tstate",  32'(tstate),     32'd0);
    chk("rst_halted",  32'(halted),     32'd0);
    chk("rst_illegal", 32'(illegal),    32'd0);
    chk("rst_ctrl",    32'(ctrl),       32'd0);
    chk("rst_alus",    32'(alus),       32'hF);
    chk("rst_done",    32'(instr_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t0_ctrl", 32'(ctrl), 32'(AR_LOAD | PC_BUS));

    // NOP: 4 cycles, back to FETCH1
    run_instr(8'h00, -1, 0, 1'b0, 1'b0);
    chk("nop_cycles", 32'(ncyc),    32'd4);
    chk("nop_fetch2", 32'(clog[1]), 32'(MEM_RD | MEM2BUS | DR_LOAD | PC_INC));
    chk("nop_fetch3", 32'(clog[2]), 32'(IR_LOAD | AR_LOAD | PC_BUS));
    chk("nop_t3",     32'(tlog[3]), 32'd3);
    chk("nop_exec",   32'(clog[3]), 32'd0);
    chk("nop_after",  32'(tstate),  32'd0);

    // LDAC with two wait cycles in T3
    run_instr(8'h01, 3, 2, 1'b0, 1'b0);
    chk("ldac_cycles",   32'(ncyc),             32'd10);
    chk("ldac_stall",    32'(clog[3]),          32'(MEM_RD | MEM2BUS));
    chk("ldac_arinc",    32'(cnt(AR_INC, -1)),  32'd1);
    chk("ldac_pcinc_t3", 32'(cnt(PC_INC, 3)),   32'd1);
    chk("ldac_drld_t3",  32'(cnt(DR_LOAD, 3)),  32'd1);
    chk("ldac_rd_t3",    32'(cnt(MEM_RD, 3)),   32'd3);
    chk("ldac_last",     32'(clog[9]),          32'(AC_LOAD | DRL_BUS));
    chk("ldac_alus",     32'(alog[9]),          32'd8);

    // JMPZ not taken (z rises at T4, ignored)
    run_instr(8'h06, -1, 0, 1'b0, 1'b1);
    chk("jmpz_nt_cycles", 32'(ncyc),              32'd5);
    chk("jmpz_nt_t3",     32'(clog[3]),           32'(PC_INC));
    chk("jmpz_nt_t4",     32'(clog[4]),           32'(PC_INC));
    chk("jmpz_nt_pcld",   32'(cnt(PC_LOAD, -1)),  32'd0);

    // JMPZ taken (z falls at T4, ignored)
    run_instr(8'h06, -1, 0, 1'b1, 1'b0);
    chk("jmpz_t_cycles", 32'(ncyc),    32'd6);
    chk("jmpz_t_t3",     32'(clog[3]), 32'(MEM_RD | MEM2BUS | DR_LOAD | AR_INC));
    chk("jmpz_t_t5",     32'(clog[5]), 32'(PC_LOAD | DRH_BUS | TR_BUS));

    run_instr(8'h07, -1, 0, 1'b0, 1'b1);
    chk("jpnz_t_cycles", 32'(ncyc), 32'd6);

    // HALT freezes the sequencer until reset
    run_instr(8'h10, -1, 0, 1'b0, 1'b0);
    chk("halt_cycles", 32'(ncyc),    32'd4);
    chk("halt_exec",   32'(clog[3]), 32'd0);
    chk("halted",      32'(halted),  32'd1);
    chk("halt_ctrl",   32'(ctrl),    32'd0);
    chk("halt_alus",   32'(alus),    32'hF);
    tick(); tick();
    chk("halt_tstate", 32'(tstate),     32'd0);
    chk("halt_done",   32'(instr_done), 32'd0);
    run = 1'b0; tick();
    run = 1'b1; tick();
    chk("halt_run_toggle", 32'(halted), 32'd1);
    chk("halt_run_ctrl",   32'(ctrl),   32'd0);
    reset = 1'b0; #1;
    chk("halt_cleared", 32'(halted), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Illegal opcode runs as NOP and the flag sticks
    run_instr(8'h3A, -1, 0, 1'b0, 1'b0);
    chk("ill_cycles", 32'(ncyc),    32'd4);
    chk("ill_flag",   32'(illegal), 32'd1);
    run_instr(8'h08, -1, 0, 1'b0, 1'b0);
    chk("add_cycles", 32'(ncyc),    32'd4);
    chk("add_ctrl",   32'(clog[3]), 32'(AC_LOAD | Z_LOAD | R_BUS));
    chk("add_alus",   32'(alog[3]), 32'd1);
    chk("ill_sticky", 32'(illegal), 32'd1);

    // STAC: run freeze at T4, then reset during the T7 write
    instr = 8'h02; mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    run = 1'b0; #1;
    chk("frz_ctrl", 32'(ctrl),       32'd0);
    chk("frz_done", 32'(instr_done), 32'd0);
    tick();
    chk("frz_tstate", 32'(tstate), 32'd4);
    run = 1'b1; #1;
    chk("stac_t4", 32'(ctrl), 32'(TR_LOAD | DR_LOAD | PC_INC | MEM_RD | MEM2BUS));
    tick();
    chk("stac_t5", 32'(ctrl), 32'(AR_LOAD | DRH_BUS | TR_BUS));
    tick();
    chk("stac_t6", 32'(ctrl), 32'(AC_BUS | DR_LOAD));
    tick();
    chk("stac_t7",      32'(ctrl),       32'(DRL_BUS | MEM_WR | BUS2MEM));
    chk("stac_t7_done", 32'(instr_done), 32'd1);
    #2;
    reset = 1'b0; #1;
    chk("async_ctrl",   32'(ctrl),   32'd0);
    chk("async_tstate", 32'(tstate), 32'd0);
    #1;
    reset = 1'b1; #1;
    chk("rel_tstate", 32'(tstate), 32'd0);
    chk("rel_ctrl",   32'(ctrl),   32'(AR_LOAD | PC_BUS));
    tick();
    chk("rel_next", 32'(tstate), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
